block_counter_ctrl: RTL and testbench
=====================================

# block_counter_ctrl

Parametrised block-index counter for the interleaver datapath: generates the read/write index sequence 0..N-1 for one code block, with N chosen per block from two parameterised sizes or a run-time custom size. Adds a start/done handshake, optional back-to-back auto-restart, and a ping-pong bank flag for double-buffered interleaver memory. Sits between the interleaver control FSM and the address generator, replacing the fixed small/large counter wrapper.

## Interface
- CNT_W, 13: counter and size width.
- SIZE_SMALL, 1056: block length N for mode 0. Legal range is 1..2^CNT_W-1.
- SIZE_LARGE, 6144: block length N for mode 1. Legal range is 1..2^CNT_W-1.

- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a block. Sampled only in IDLE.
- count_enable  input  1  advance the index this cycle. Sampled only in RUN.
- block_size  input  2  mode: 0 = small, 1 = large, 2 = custom, 3 = reserved.
- custom_size  input  CNT_W  block length N for mode 2.
- auto_restart  input  1  on block end, start the next block immediately.
- count  output  CNT_W  current index.
- target  output  CNT_W  latched last index, N-1.
- valid  output  1  high in RUN; count is meaningful.
- last  output  1  valid && count==target.
- done  output  1  one-cycle pulse after the final index is consumed.
- busy  output  1  high in RUN.
- bank  output  1  ping-pong buffer select; toggles once per completed block.
- err  output  1  one-cycle pulse when a start is rejected.

## Operation
- Two states, IDLE and RUN.
- Reset (asynchronous, active-low) forces state=IDLE and sets count, target, bank, done and err to 0. It takes effect immediately, including mid-block. The partial block is discarded: no done pulse and no bank toggle.
- IDLE:
  - count is held at 0.
  - start=1 with a legal mode: latch target=N-1 and go to RUN with count=0.
  - start=1 with block_size=3, or with block_size=2 and custom_size=0: err=1 for one cycle; stay in IDLE; target is unchanged.
- RUN:
  - If count_enable=1 and last=0: count <= count+1.
  - If count_enable=1 and last=1 (final index consumed):
    - done=1 next cycle, and bank toggles.
    - If auto_restart=1, the mode is legal and start is not required: re-latch target from the current block_size/custom_size, set count=0 and stay in RUN.
    - If the re-latched mode is illegal: err=1 and go to IDLE.
    - Otherwise go to IDLE.
  - If count_enable=0: hold count.
  - start is ignored in RUN.
- N=1: target=0, so last is high on the first RUN cycle.
- block_size and custom_size are sampled only at latch time. Changes during RUN have no effect.
- count never exceeds target. No wrap past 2^CNT_W-1 is possible because N ≤ 2^CNT_W-1.
- Arithmetic is unsigned, CNT_W bits: target = N-1.

## Timing
- Start to first index: start sampled high at edge t → valid=1, count=0 after edge t.
- Index rate: one index per cycle while count_enable=1. There are no bubbles inside a block.
- Block end: final count_enable sampled at edge t → done, bank toggle, and either count=0 (auto-restart) or valid=0 (IDLE), all after edge t.
  - With auto_restart, the next block's index 0 is valid in the same cycle done is high: zero-gap back-to-back blocks.
  - done and err are registered pulses, exactly one cycle wide.
- Reset deassertion: the first start is accepted on the first rising edge after reset is released.

## Structure
- The shared interleaver package holds:
  - mode encodings: MODE_SMALL=2'd0, MODE_LARGE=2'd1, MODE_CUSTOM=2'd2, MODE_RSVD=2'd3;
  - the state enum {IDLE, RUN};
  - default size constants 1056 and 6144.
- One sub-module, block_index_counter: a CNT_W-bit counter with asynchronous active-low clear, synchronous clear and enable. The top level holds the FSM, the target latch, the legality check and bank/done/err.
- Elaboration-time check: SIZE_SMALL and SIZE_LARGE must each be within 1..2^CNT_W-1.

## Test plan
- Small block: mode 0, start, count_enable held high → count goes 0..1055. last is high only at 1055. done pulses the cycle after, bank goes 0→1, then back to IDLE with count=0.
- Large block with gaps: mode 1, count_enable toggling 1/0 → count advances only on enabled cycles, reaches 6143, done once. Total RUN cycles = 6144 + number of gap cycles.
- Auto-restart: auto_restart=1, mode 2 with custom_size=5, then switch to mode 0 while the first block runs.
  - First block is 0..4; the mode change has no effect on it.
  - Second block starts at count=0 in the done cycle with target=1055.
  - bank toggles at each block end.
- Illegal starts:
  - mode 3 → err one cycle, stays in IDLE.
  - custom_size=0 → err one cycle, stays in IDLE.
  - custom_size=1 → target=0, last on the first cycle, done after one enable.
- Reset mid-block: assert reset at count=300 → all outputs are 0 immediately, no done, bank=0. A new start after release runs normally from 0.
- Start ignored while busy: pulse start at count=10 → no restart, count continues 11, 12, ….

Source files
------------

// File: rtl/block_counter_ctrl_pkg.sv
// Shared interleaver definitions: block-size mode encodings, controller states
// and default block lengths.
package block_counter_ctrl_pkg;

    localparam int unsigned DEF_CNT_W      = 13;
    localparam int unsigned DEF_SIZE_SMALL = 1056;
    localparam int unsigned DEF_SIZE_LARGE = 6144;

    typedef enum logic [1:0] {
        MODE_SMALL  = 2'd0,
        MODE_LARGE  = 2'd1,
        MODE_CUSTOM = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/block_index_counter.sv
// W-bit index counter with asynchronous active-low clear, synchronous clear
// (priority) and count enable.
module block_index_counter #(
    parameter int unsigned W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/block_counter_ctrl.sv
// Block-index sequencer for the interleaver: start/done handshake, per-block
// size latch, back-to-back auto-restart and ping-pong bank select.
module block_counter_ctrl
    import block_counter_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned SIZE_SMALL = DEF_SIZE_SMALL,
    parameter int unsigned SIZE_LARGE = DEF_SIZE_LARGE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             count_enable,
    input  logic [1:0]       block_size,
    input  logic [CNT_W-1:0] custom_size,
    input  logic             auto_restart,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] target,
    output logic             valid,
    output logic             last,
    output logic             done,
    output logic             busy,
    output logic             bank,
    output logic             err
);

    localparam longint unsigned MAX_N = (64'd1 << CNT_W) - 64'd1;

    // Block lengths must be representable and non-zero so target never underflows.
    if (64'(SIZE_SMALL) < 64'd1 || 64'(SIZE_SMALL) > MAX_N) begin : g_bad_small
        $error("block_counter_ctrl: SIZE_SMALL out of range 1..2^CNT_W-1");
    end
    if (64'(SIZE_LARGE) < 64'd1 || 64'(SIZE_LARGE) > MAX_N) begin : g_bad_large
        $error("block_counter_ctrl: SIZE_LARGE out of range 1..2^CNT_W-1");
    end

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] w_target_nxt;
    logic             r_bank;
    logic             w_bank_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_last;
    logic             w_last_nxt;

    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_clr;
    logic             w_inc;

    logic [CNT_W-1:0] w_size;
    logic             w_legal;
    logic [CNT_W-1:0] w_new_target;
    logic             w_at_end;

    // Block length and legality for the currently presented mode.
    always_comb begin
        w_size  = '0;
        w_legal = 1'b0;
        case (block_size)
            MODE_SMALL: begin
                w_size  = CNT_W'(SIZE_SMALL);
                w_legal = 1'b1;
            end
            MODE_LARGE: begin
                w_size  = CNT_W'(SIZE_LARGE);
                w_legal = 1'b1;
            end
            MODE_CUSTOM: begin
                w_size  = custom_size;
                w_legal = |custom_size;
            end
            default: begin
                w_size  = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_new_target = w_size - CNT_W'(1);
    assign w_at_end     = (w_count == r_target);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_target <= '0;
            r_bank   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_bank   <= w_bank_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_last   <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_bank_nxt   = r_bank;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_clr        = 1'b0;
        w_inc        = 1'b0;

        case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (start) begin
                    if (w_legal) begin
                        w_target_nxt = w_new_target;
                        w_state_nxt  = RUN;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (count_enable) begin
                    if (!w_at_end) begin
                        w_inc = 1'b1;
                    end else begin
                        // Final index consumed: close the block, optionally chain the next.
                        w_done_nxt = 1'b1;
                        w_bank_nxt = ~r_bank;
                        w_clr      = 1'b1;
                        if (auto_restart && w_legal) begin
                            w_target_nxt = w_new_target;
                        end else begin
                            w_err_nxt   = auto_restart;
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_clr       = 1'b1;
            end
        endcase

        if (w_clr) begin
            w_count_nxt = '0;
        end else if (w_inc) begin
            w_count_nxt = w_count + CNT_W'(1);
        end else begin
            w_count_nxt = w_count;
        end
        w_last_nxt = (w_state_nxt == RUN) && (w_count_nxt == w_target_nxt);
    end

    block_index_counter #(
        .W (CNT_W)
    ) u_index_counter (
        .clk     (clk),
        .rst_n   (reset),
        .i_clr   (w_clr),
        .i_en    (w_inc),
        .o_count (w_count)
    );

    assign count  = w_count;
    assign target = r_target;
    assign valid  = (r_state == RUN);
    assign busy   = (r_state == RUN);
    assign last   = r_last;
    assign done   = r_done;
    assign bank   = r_bank;
    assign err    = r_err;

endmodule

// File: tb/tb_block_counter_ctrl.sv
// Self-checking bench for block_counter_ctrl: directed scenarios plus random
// traffic, all compared each cycle against a behavioural block model.
module tb_block_counter_ctrl;

    localparam int unsigned CNT_W = 13;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             count_enable;
    logic [1:0]       block_size;
    logic [CNT_W-1:0] custom_size;
    logic             auto_restart;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] target;
    logic             valid;
    logic             last;
    logic             done;
    logic             busy;
    logic             bank;
    logic             err;

    block_counter_ctrl #(
        .CNT_W      (CNT_W),
        .SIZE_SMALL (1056),
        .SIZE_LARGE (6144)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .count_enable (count_enable),
        .block_size   (block_size),
        .custom_size  (custom_size),
        .auto_restart (auto_restart),
        .count        (count),
        .target       (target),
        .valid        (valid),
        .last         (last),
        .done         (done),
        .busy         (busy),
        .bank         (bank),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: a block in progress, its current index, last index and the bank.
    bit m_active;
    int m_count;
    int m_target;
    bit m_bank;
    bit m_done;
    bit m_err;

    function automatic int blk_len(input logic [1:0] mode, input logic [CNT_W-1:0] cs);
        case (mode)
            2'd0:    return 1056;
            2'd1:    return 6144;
            2'd2:    return int'(cs);
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_active = 0; m_count = 0; m_target = 0;
        m_bank = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_update();
        int n;
        bit d, e;
        d = 0; e = 0;
        if (!m_active) begin
            if (start) begin
                n = blk_len(block_size, custom_size);
                if (n == 0) e = 1;
                else begin m_active = 1; m_target = n - 1; m_count = 0; end
            end
        end else if (count_enable) begin
            if (m_count < m_target) m_count++;
            else begin
                d = 1; m_bank = !m_bank; m_count = 0;
                if (auto_restart) begin
                    n = blk_len(block_size, custom_size);
                    if (n == 0) begin e = 1; m_active = 0; end
                    else m_target = n - 1;
                end else m_active = 0;
            end
        end
        m_done = d; m_err = e;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("count",  32'(count),  m_active ? m_count : 0);
        chk("target", 32'(target), m_target);
        chk("valid",  32'(valid),  32'(m_active));
        chk("busy",   32'(busy),   32'(m_active));
        chk("last",   32'(last),   32'(m_active && (m_count == m_target)));
        chk("done",   32'(done),   32'(m_done));
        chk("bank",   32'(bank),   32'(m_bank));
        chk("err",    32'(err),    32'(m_err));
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_to_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done) begin ok = 1; break; end
        end
    endtask

    int lastidx, lastseen, runcyc, gaps, maxcnt;
    bit ok;

    initial begin
        reset = 1'b0; start = 0; count_enable = 0; block_size = 0;
        custom_size = '0; auto_restart = 0;
        model_reset();
        #1;
        compare_all();
        chk("reset_bank_lit", 32'(bank), 0);
        @(negedge clk);
        reset = 1'b1;

        // Small block, enable held high.
        block_size = 2'd0; start = 1; count_enable = 1;
        step();
        start = 0;
        lastidx = -1; lastseen = 0;
        ok = 0;
        for (int i = 0; i < 1100; i++) begin
            if (valid && last) begin lastidx = int'(count); lastseen++; end
            step();
            if (done) begin ok = 1; break; end
        end
        chk("small_done_seen", 32'(ok), 1);
        chk("small_last_idx", lastidx, 1055);
        chk("small_last_once", lastseen, 1);
        chk("small_bank_lit", 32'(bank), 1);
        chk("small_idle_lit", 32'(valid), 0);

        // Large block with random enable gaps.
        block_size = 2'd1; start = 1; count_enable = 0;
        step();
        start = 0;
        runcyc = 0; gaps = 0; ok = 0;
        for (int i = 0; i < 14000; i++) begin
            count_enable = 1'($urandom);
            if (busy) begin runcyc++; if (!count_enable) gaps++; end
            step();
            if (done) begin ok = 1; break; end
        end
        chk("large_done_seen", 32'(ok), 1);
        chk("large_run_cycles", runcyc, 6144 + gaps);
        chk("large_bank_lit", 32'(bank), 0);

        // Auto-restart: 5-entry custom block chained into a small block.
        count_enable = 1; auto_restart = 1; block_size = 2'd2; custom_size = 13'd5; start = 1;
        step();
        start = 0; block_size = 2'd0;
        chk("ar_target_lit", 32'(target), 4);
        maxcnt = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (int'(count) > maxcnt) maxcnt = int'(count);
            step();
            if (done) begin ok = 1; break; end
        end
        chk("ar_first_done", 32'(ok), 1);
        chk("ar_first_max", maxcnt, 4);
        chk("ar_restart_cnt", 32'(count), 0);
        chk("ar_restart_valid", 32'(valid), 1);
        chk("ar_restart_target", 32'(target), 1055);
        chk("ar_bank1_lit", 32'(bank), 1);
        auto_restart = 0;
        run_to_done(1100, ok);
        chk("ar_second_done", 32'(ok), 1);
        chk("ar_bank2_lit", 32'(bank), 0);

        // Illegal starts, then a single-entry block.
        count_enable = 0; block_size = 2'd3; start = 1;
        step();
        chk("rsvd_err_lit", 32'(err), 1);
        chk("rsvd_idle_lit", 32'(busy), 0);
        start = 0;
        step();
        chk("err_pulse_lit", 32'(err), 0);
        block_size = 2'd2; custom_size = '0; start = 1;
        step();
        chk("cs0_err_lit", 32'(err), 1);
        custom_size = 13'd1;
        step();
        chk("cs1_target_lit", 32'(target), 0);
        chk("cs1_last_lit", 32'(last), 1);
        start = 0; count_enable = 1;
        step();
        chk("cs1_done_lit", 32'(done), 1);
        chk("cs1_busy_lit", 32'(busy), 0);

        // Reset in the middle of a block.
        block_size = 2'd0; start = 1;
        step();
        start = 0;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (count == 13'd300) begin ok = 1; break; end
            step();
        end
        chk("rst_reach_300", 32'(ok), 1);
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst_count_lit", 32'(count), 0);
        chk("rst_bank_lit", 32'(bank), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        block_size = 2'd2; custom_size = 13'd3; start = 1;
        step();
        start = 0;
        run_to_done(10, ok);
        chk("post_rst_done", 32'(ok), 1);

        // Start while busy is ignored.
        block_size = 2'd0; start = 1;
        step();
        start = 0;
        for (int i = 0; i < 20 && count != 13'd10; i++) step();
        block_size = 2'd2; custom_size = 13'd2; start = 1;
        step();
        chk("busy_start_11", 32'(count), 11);
        start = 0;
        step();
        chk("busy_start_12", 32'(count), 12);
        run_to_done(1100, ok);
        chk("busy_start_done", 32'(ok), 1);

        // Random traffic, mostly short custom blocks.
        for (int i = 0; i < 20000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 70)      block_size = 2'd2;
            else if (r < 85) block_size = 2'd3;
            else if (r < 98) block_size = 2'd0;
            else             block_size = 2'd1;
            custom_size  = ($urandom_range(0, 19) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 11));
            start        = ($urandom_range(0, 2) == 0);
            count_enable = ($urandom_range(0, 3) != 0);
            auto_restart = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
